hazard_ctrl: RTL and testbench

- Central hazard and sequencing controller for the five-stage MIPS pipeline.
- Drives the stall, clear and flush inputs of the fetch/decode/execute pipeline registers.
- Produces the decode-stage and execute-stage forwarding selects.
- Tracks the multi-cycle multiply/divide unit, so HI/LO-dependent instructions are held in decode until the result exists.

---
 rtl/pipeline_pkg.sv | 35 +++
 rtl/md_seq.sv | 70 +++++++
 rtl/hazard_ctrl.sv | 98 +++++++++
 tb/tb_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and default timing for the pipeline hazard controller.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    localparam int DEF_MULT_CYCLES = 4;
    localparam int DEF_DIV_CYCLES  = 32;
    localparam int DEF_CNT_W       = 6;

    // Register 0 is hardwired to zero, so it never forwards; M outranks W.
    function automatic fwd_sel_e fwd_e_sel(
        input logic [4:0] src,
        input logic       wr_m,
        input logic [4:0] reg_m,
        input logic       wr_w,
        input logic [4:0] reg_w
    );
        if (wr_m && (reg_m != 5'd0) && (reg_m == src))
            return FWD_M;
        else if (wr_w && (reg_w != 5'd0) && (reg_w == src))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/md_seq.sv
// Multiply/divide occupancy sequencer: busy while the unit computes, done on the final cycle.
//   state   | meaning
//   MD_IDLE | unit free, waiting for a mult/div in execute
//   MD_BUSY | unit computing; counter holds remaining cycles minus one
module md_seq
    import pipeline_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic div_i,
    output logic busy_o,
    output logic done_o
);

    md_state_e          r_state;
    md_state_e          w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_load_val;

    assign w_load_val = div_i ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            MD_IDLE: begin
                if (start_i) begin
                    w_state_nxt = MD_BUSY;
                    w_cnt_nxt   = w_load_val;
                end
            end
            MD_BUSY: begin
                // A start at nonzero count is ignored; only the final cycle may chain.
                if (r_cnt == '0) begin
                    if (start_i) begin
                        w_cnt_nxt = w_load_val;
                    end else begin
                        w_state_nxt = MD_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = MD_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign busy_o = (r_state == MD_BUSY);
    assign done_o = (r_state == MD_BUSY) && (r_cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and mult/div sequencing control for the five-stage MIPS pipeline.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] rs_d_i,
    input  logic [4:0] rt_d_i,
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rt_e_i,
    input  logic [4:0] write_reg_e_i,
    input  logic [4:0] write_reg_m_i,
    input  logic [4:0] write_reg_w_i,
    input  logic       reg_write_e_i,
    input  logic       reg_write_m_i,
    input  logic       reg_write_w_i,
    input  logic       mem_to_reg_e_i,
    input  logic       mem_to_reg_m_i,
    input  logic       branch_d_i,
    input  logic       jump_reg_d_i,
    input  logic       branch_taken_d_i,
    input  logic       md_start_e_i,
    input  logic       md_div_e_i,
    input  logic       hilo_use_d_i,
    output logic       stall_f_o,
    output logic       stall_d_o,
    output logic       flush_d_o,
    output logic       flush_e_o,
    output logic       forward_a_d_o,
    output logic       forward_b_d_o,
    output logic [1:0] forward_a_e_o,
    output logic [1:0] forward_b_e_o,
    output logic       md_busy_o,
    output logic       md_done_o
);

    fwd_sel_e w_fwd_a_e;
    fwd_sel_e w_fwd_b_e;
    logic     w_md_busy;
    logic     w_md_done;
    logic     w_rs_pending;
    logic     w_rt_pending;
    logic     w_lw_stall;
    logic     w_br_stall;
    logic     w_md_stall;
    logic     w_stall;

    md_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_seq (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (md_start_e_i),
        .div_i   (md_div_e_i),
        .busy_o  (w_md_busy),
        .done_o  (w_md_done)
    );

    assign w_fwd_a_e = fwd_e_sel(rs_e_i, reg_write_m_i, write_reg_m_i, reg_write_w_i, write_reg_w_i);
    assign w_fwd_b_e = fwd_e_sel(rt_e_i, reg_write_m_i, write_reg_m_i, reg_write_w_i, write_reg_w_i);

    assign forward_a_e_o = w_fwd_a_e;
    assign forward_b_e_o = w_fwd_b_e;

    assign forward_a_d_o = reg_write_m_i && (write_reg_m_i != 5'd0) && (write_reg_m_i == rs_d_i);
    assign forward_b_d_o = reg_write_m_i && (write_reg_m_i != 5'd0) && (write_reg_m_i == rt_d_i);

    assign w_lw_stall = mem_to_reg_e_i && ((rt_e_i == rs_d_i) || (rt_e_i == rt_d_i));

    // A decode-stage compare needs operands that are still in flight from E, or loading in M.
    assign w_rs_pending = (reg_write_e_i && (write_reg_e_i == rs_d_i)) ||
                          (mem_to_reg_m_i && (write_reg_m_i == rs_d_i));
    assign w_rt_pending = (reg_write_e_i && (write_reg_e_i == rt_d_i)) ||
                          (mem_to_reg_m_i && (write_reg_m_i == rt_d_i));

    assign w_br_stall = (branch_d_i && (w_rs_pending || w_rt_pending)) ||
                        (jump_reg_d_i && w_rs_pending);

    // The done cycle already has the result available, so HI/LO users may proceed.
    assign w_md_stall = hilo_use_d_i && w_md_busy && !w_md_done;

    assign w_stall = w_lw_stall || w_br_stall || w_md_stall;

    assign stall_f_o = w_stall;
    assign stall_d_o = w_stall;
    assign flush_e_o = w_stall;
    assign flush_d_o = branch_taken_d_i && !w_stall;

    assign md_busy_o = w_md_busy;
    assign md_done_o = w_md_done;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then randomized traffic against a cycle-indexed model.
module tb_hazard_ctrl;

    localparam int MULT_C = 4;
    localparam int DIV_C  = 32;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [4:0] rs_d_i, rt_d_i, rs_e_i, rt_e_i;
    logic [4:0] write_reg_e_i, write_reg_m_i, write_reg_w_i;
    logic       reg_write_e_i, reg_write_m_i, reg_write_w_i;
    logic       mem_to_reg_e_i, mem_to_reg_m_i;
    logic       branch_d_i, jump_reg_d_i, branch_taken_d_i;
    logic       md_start_e_i, md_div_e_i, hilo_use_d_i;
    logic       stall_f_o, stall_d_o, flush_d_o, flush_e_o;
    logic       forward_a_d_o, forward_b_d_o;
    logic [1:0] forward_a_e_o, forward_b_e_o;
    logic       md_busy_o, md_done_o;

    always #5 clk_i = ~clk_i;

    hazard_ctrl #(
        .MULT_CYCLES (MULT_C),
        .DIV_CYCLES  (DIV_C),
        .CNT_W       (6)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .rs_d_i           (rs_d_i),
        .rt_d_i           (rt_d_i),
        .rs_e_i           (rs_e_i),
        .rt_e_i           (rt_e_i),
        .write_reg_e_i    (write_reg_e_i),
        .write_reg_m_i    (write_reg_m_i),
        .write_reg_w_i    (write_reg_w_i),
        .reg_write_e_i    (reg_write_e_i),
        .reg_write_m_i    (reg_write_m_i),
        .reg_write_w_i    (reg_write_w_i),
        .mem_to_reg_e_i   (mem_to_reg_e_i),
        .mem_to_reg_m_i   (mem_to_reg_m_i),
        .branch_d_i       (branch_d_i),
        .jump_reg_d_i     (jump_reg_d_i),
        .branch_taken_d_i (branch_taken_d_i),
        .md_start_e_i     (md_start_e_i),
        .md_div_e_i       (md_div_e_i),
        .hilo_use_d_i     (hilo_use_d_i),
        .stall_f_o        (stall_f_o),
        .stall_d_o        (stall_d_o),
        .flush_d_o        (flush_d_o),
        .flush_e_o        (flush_e_o),
        .forward_a_d_o    (forward_a_d_o),
        .forward_b_d_o    (forward_b_d_o),
        .forward_a_e_o    (forward_a_e_o),
        .forward_b_e_o    (forward_b_e_o),
        .md_busy_o        (md_busy_o),
        .md_done_o        (md_done_o)
    );

    // Expected vector: {stall_f, stall_d, flush_d, flush_e, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, busy, done}
    logic [11:0] exp_q[$];
    int          cyc_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;

    // Model of the mult/div unit: the cycle number at which the pending result becomes ready.
    bit          m_active = 1'b0;
    int          m_ready  = 0;

    function automatic logic [1:0] ref_fwd_e(input logic [4:0] src);
        if (reg_write_m_i && write_reg_m_i != 0 && write_reg_m_i == src) return 2'b10;
        if (reg_write_w_i && write_reg_w_i != 0 && write_reg_w_i == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit in_flight(input logic [4:0] r);
        return (reg_write_e_i && write_reg_e_i == r) || (mem_to_reg_m_i && write_reg_m_i == r);
    endfunction

    task automatic clear_in();
        rs_d_i = 0; rt_d_i = 0; rs_e_i = 0; rt_e_i = 0;
        write_reg_e_i = 0; write_reg_m_i = 0; write_reg_w_i = 0;
        reg_write_e_i = 0; reg_write_m_i = 0; reg_write_w_i = 0;
        mem_to_reg_e_i = 0; mem_to_reg_m_i = 0;
        branch_d_i = 0; jump_reg_d_i = 0; branch_taken_d_i = 0;
        md_start_e_i = 0; md_div_e_i = 0; hilo_use_d_i = 0;
    endtask

    task automatic begin_cycle();
        @(negedge clk_i);
        clear_in();
    endtask

    // Called once per cycle after inputs settle: predicts this cycle, then advances the model past the next edge.
    task automatic push_expect();
        bit busy, done, lw, br, mds, stall, fad, fbd;
        logic [1:0] fae, fbe;
        #1;
        if (rst_i) m_active = 1'b0;
        busy  = m_active && (cyc <= m_ready);
        done  = busy && (cyc == m_ready);
        lw    = mem_to_reg_e_i && (rt_e_i == rs_d_i || rt_e_i == rt_d_i);
        br    = (branch_d_i && (in_flight(rs_d_i) || in_flight(rt_d_i))) ||
                (jump_reg_d_i && in_flight(rs_d_i));
        mds   = hilo_use_d_i && busy && !done;
        stall = lw || br || mds;
        fad   = reg_write_m_i && write_reg_m_i != 0 && write_reg_m_i == rs_d_i;
        fbd   = reg_write_m_i && write_reg_m_i != 0 && write_reg_m_i == rt_d_i;
        fae   = ref_fwd_e(rs_e_i);
        fbe   = ref_fwd_e(rt_e_i);
        exp_q.push_back({stall, stall, branch_taken_d_i && !stall, stall, fad, fbd, fae, fbe, busy, done});
        cyc_q.push_back(cyc);
        if (!rst_i && md_start_e_i && (!busy || done)) begin
            m_active = 1'b1;
            m_ready  = cyc + (md_div_e_i ? DIV_C : MULT_C);
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            begin_cycle();
            push_expect();
        end
    endtask

    initial begin : monitor
        logic [11:0] e, a;
        int c;
        forever begin
            @(negedge clk_i);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                a = {stall_f_o, stall_d_o, flush_d_o, flush_e_o, forward_a_d_o, forward_b_d_o,
                     forward_a_e_o, forward_b_e_o, md_busy_o, md_done_o};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle_%0d outputs: got %b expected %b", c, a, e);
                end
            end
        end
    end

    initial begin : driver
        clear_in();
        rst_i = 1'b1;
        idle(2);
        begin_cycle(); rst_i = 1'b0; push_expect();

        // Forward priority: M over W, register 0 never forwards
        begin_cycle(); rs_e_i = 5; reg_write_m_i = 1; write_reg_m_i = 5; reg_write_w_i = 1; write_reg_w_i = 5; push_expect();
        begin_cycle(); rs_e_i = 5; reg_write_m_i = 0; write_reg_m_i = 5; reg_write_w_i = 1; write_reg_w_i = 5; push_expect();
        begin_cycle(); rs_e_i = 0; reg_write_m_i = 1; write_reg_m_i = 0; rt_d_i = 0; push_expect();
        begin_cycle(); rt_e_i = 9; rs_d_i = 9; reg_write_w_i = 1; write_reg_w_i = 9; reg_write_m_i = 1; write_reg_m_i = 9; push_expect();

        // Load-use
        begin_cycle(); mem_to_reg_e_i = 1; rt_e_i = 8; rs_d_i = 8; push_expect();
        begin_cycle(); mem_to_reg_e_i = 0; rt_e_i = 8; rs_d_i = 8; push_expect();

        // Branch hazard then redirect; jump-register checks rs only
        begin_cycle(); branch_d_i = 1; rs_d_i = 3; reg_write_e_i = 1; write_reg_e_i = 3; branch_taken_d_i = 1; push_expect();
        begin_cycle(); branch_d_i = 1; rs_d_i = 3; branch_taken_d_i = 1; push_expect();
        begin_cycle(); push_expect();
        begin_cycle(); jump_reg_d_i = 1; rs_d_i = 2; rt_d_i = 6; mem_to_reg_m_i = 1; write_reg_m_i = 6; branch_taken_d_i = 1; push_expect();
        begin_cycle(); jump_reg_d_i = 1; rs_d_i = 6; mem_to_reg_m_i = 1; write_reg_m_i = 6; branch_taken_d_i = 1; push_expect();

        // MULT then MFHI held until the done cycle
        begin_cycle(); md_start_e_i = 1; md_div_e_i = 0; push_expect();
        for (int k = 0; k < 6; k++) begin
            begin_cycle(); hilo_use_d_i = 1; push_expect();
        end

        // DIV chained in the done cycle
        begin_cycle(); md_start_e_i = 1; md_div_e_i = 1; push_expect();
        idle(DIV_C - 1);
        begin_cycle(); md_start_e_i = 1; md_div_e_i = 1; hilo_use_d_i = 1; push_expect();
        idle(DIV_C + 2);

        // Reset while the divide counter sits at 10
        begin_cycle(); md_start_e_i = 1; md_div_e_i = 1; push_expect();
        idle(DIV_C - 11);
        begin_cycle(); rst_i = 1'b1; push_expect();
        begin_cycle(); rst_i = 1'b0; push_expect();
        idle(DIV_C + 2);

        // Randomized traffic over a small register range so collisions are frequent
        for (int k = 0; k < 700; k++) begin
            begin_cycle();
            rst_i            = ($urandom_range(0, 249) == 0);
            rs_d_i           = 5'($urandom_range(0, 7));
            rt_d_i           = 5'($urandom_range(0, 7));
            rs_e_i           = 5'($urandom_range(0, 7));
            rt_e_i           = 5'($urandom_range(0, 7));
            write_reg_e_i    = 5'($urandom_range(0, 7));
            write_reg_m_i    = 5'($urandom_range(0, 7));
            write_reg_w_i    = 5'($urandom_range(0, 7));
            reg_write_e_i    = 1'($urandom_range(0, 1));
            reg_write_m_i    = 1'($urandom_range(0, 1));
            reg_write_w_i    = 1'($urandom_range(0, 1));
            mem_to_reg_e_i   = ($urandom_range(0, 3) == 0);
            mem_to_reg_m_i   = ($urandom_range(0, 3) == 0);
            branch_d_i       = ($urandom_range(0, 3) == 0);
            jump_reg_d_i     = ($urandom_range(0, 5) == 0);
            branch_taken_d_i = 1'($urandom_range(0, 1));
            md_start_e_i     = ($urandom_range(0, 5) == 0);
            md_div_e_i       = ($urandom_range(0, 3) == 0);
            hilo_use_d_i     = 1'($urandom_range(0, 1));
            push_expect();
        end
        begin_cycle(); rst_i = 1'b0; push_expect();
        idle(2);

        @(negedge clk_i);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
